// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the DMEM load/store unit: size codes, FSM states
// and the alignment helper used at request accept.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_t;

  // Illegal size is reported separately; this only covers alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU-side request/response channel of the load/store unit.
interface dmem_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lsu_lane.sv
// Little-endian lane logic: load extraction/extension and sub-word store merge
// into the word read back from DMEM.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = 8'(word >> {addr_lo, 3'b000});
  assign lane_half = 16'(word >> {addr_lo[1], 4'b0000});

  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
      default: load_data = word;
    endcase
  end

  // Each byte lane picks either the old memory byte or the matching store byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       en;
    logic [7:0] src;

    always_comb begin
      en  = 1'b0;
      src = wdata[7:0];
      case (size)
        SZ_BYTE: begin
          en  = (addr_lo == LANE);
          src = wdata[7:0];
        end
        SZ_HALF: begin
          en  = (addr_lo[1] == LANE[1]);
          src = LANE[0] ? wdata[15:8] : wdata[7:0];
        end
        SZ_WORD: begin
          en  = 1'b1;
          src = wdata[8*gi +: 8];
        end
        default: begin
          en  = 1'b0;
          src = wdata[7:0];
        end
      endcase
    end

    assign store_word[8*gi +: 8] = en ? src : word[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving DMEM: one request at a time, read-modify-write for
// sub-word stores, sign/zero-extended loads, all outputs registered.
module dmem_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  dmem_lsu_if.slave   cpu,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  localparam logic [2:0] IDLE = 3'(ST_IDLE);
  localparam logic [2:0] RD   = 3'(ST_RD);
  localparam logic [2:0] CAP  = 3'(ST_CAP);
  localparam logic [2:0] WR   = 3'(ST_WR);
  localparam logic [2:0] RESP = 3'(ST_RESP);

  logic [2:0]  state_reg, state_next;
  logic [1:0]  addr_lo_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;

  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic [31:0] address_reg;
  logic [31:0] data_in_reg;
  logic        mem_write_reg;
  logic        mem_read_reg;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept  = cpu.req_valid & req_ready_reg & (state_reg == IDLE);
  assign req_err = (cpu.req_size == SZ_ILL) | is_misaligned(cpu.req_addr[1:0], cpu.req_size);

  lsu_lane u_lane (
    .word        (DMEM_data_out),
    .addr_lo     (addr_lo_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)
            state_next = RESP;
          else if (cpu.req_write && cpu.req_size == SZ_WORD)
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = write_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and handshake outputs are registered from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      addr_lo_reg    <= 2'b00;
      size_reg       <= SZ_BYTE;
      uns_reg        <= 1'b0;
      write_reg      <= 1'b0;
      wdata_reg      <= '0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      address_reg    <= '0;
      data_in_reg    <= '0;
      mem_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= (state_next == IDLE);
      resp_valid_reg <= (state_next == RESP);
      mem_read_reg   <= (state_next == RD);
      mem_write_reg  <= (state_next == WR);
      resp_err_reg   <= accept & req_err;
      resp_rdata_reg <= (state_reg == CAP && !write_reg) ? load_data : 32'd0;

      if (accept) begin
        addr_lo_reg <= cpu.req_addr[1:0];
        size_reg    <= cpu.req_size;
        uns_reg     <= cpu.req_unsigned;
        write_reg   <= cpu.req_write;
        wdata_reg   <= cpu.req_wdata;
        address_reg <= {cpu.req_addr[31:2], 2'b00};
        data_in_reg <= cpu.req_wdata;
      end else if (state_reg == CAP && write_reg) begin
        data_in_reg <= store_word;
      end
    end
  end

  assign cpu.req_ready  = req_ready_reg;
  assign cpu.resp_valid = resp_valid_reg;
  assign cpu.resp_err   = resp_err_reg;
  assign cpu.resp_rdata = resp_rdata_reg;

  assign DMEM_address   = address_reg;
  assign DMEM_data_in   = data_in_reg;
  assign DMEM_mem_write = mem_write_reg;
  assign DMEM_mem_read  = mem_read_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-level reference memory, expected
// responses and DMEM strobes queued at accept, checked by a monitor.
`timescale 1ns/1ps
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  dmem_lsu_if bus();

  dmem_lsu dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu            (bus),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int nresp  = 0;

  logic [31:0] dmem [0:63] = '{default: 32'd0};
  logic [7:0]  ref_mem [0:255] = '{default: 8'd0};

  int  prev_acc = 0;
  int  prev_lat = 0;
  bit  chain_valid = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (DMEM_mem_read) DMEM_data_out <= dmem[DMEM_address[7:2]];
    else               DMEM_data_out <= $urandom();
    if (DMEM_mem_write) dmem[DMEM_address[7:2]] <= DMEM_data_in;
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[8'({a[31:2], 2'b00} + 32'(i))]) << (8 * i));
    return v;
  endfunction

  // Presents a request (valid stays high afterwards) and queues what must follow.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] exp_val,
                       input bit complete);
    int waitc, acc, lat;
    bit err;
    logic [31:0] exp_rd;
    wr_t w;
    resp_t r;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      check(1'b0, "ready_timeout", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      chain_valid = 0;
      return;
    end
    acc = cycle;
    err = ref_err(addr, sz);
    exp_rd = 32'd0;
    if (err) lat = 1;
    else if (wr && sz == SZ_WORD) lat = 2;
    else if (wr) lat = 4;
    else lat = 3;
    if (!err && !(wr && sz == SZ_WORD)) rd_q.push_back({addr[31:2], 2'b00});
    if (!err && !wr) exp_rd = ref_load(addr, sz, uns);
    if (!err && wr && complete) begin
      for (int i = 0; i < (1 << sz); i++) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
      w.addr = {addr[31:2], 2'b00};
      w.data = ref_word(addr);
      wr_q.push_back(w);
    end
    if (use_exp) exp_rd = exp_val;
    if (complete) begin
      r.rdata = exp_rd;
      r.err   = err;
      r.cyc   = acc + lat;
      resp_q.push_back(r);
    end
    if (chain_valid) check(acc - prev_acc == prev_lat + 1, "b2b_accept_gap", 32'(acc - prev_acc), 32'(prev_lat + 1));
    prev_acc = acc;
    prev_lat = lat;
    chain_valid = complete;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chain_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  resp_t       mon_r;
  wr_t         mon_w;
  logic [31:0] mon_a;

  always @(negedge clk) begin
    if (DMEM_mem_read || DMEM_mem_write)
      check(!(DMEM_mem_read && DMEM_mem_write), "strobe_exclusive", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
    if (DMEM_mem_read) begin
      if (rd_q.size() == 0) check(1'b0, "unexpected_read", DMEM_address, 32'd0);
      else begin
        mon_a = rd_q.pop_front();
        check(DMEM_address == mon_a, "read_addr", DMEM_address, mon_a);
      end
    end
    if (DMEM_mem_write) begin
      if (wr_q.size() == 0) check(1'b0, "unexpected_write", DMEM_address, 32'd0);
      else begin
        mon_w = wr_q.pop_front();
        check(DMEM_address == mon_w.addr, "write_addr", DMEM_address, mon_w.addr);
        check(DMEM_data_in == mon_w.data, "write_data", DMEM_data_in, mon_w.data);
      end
    end
    if (bus.resp_valid) begin
      nresp++;
      if (resp_q.size() == 0) check(1'b0, "unexpected_resp", bus.resp_rdata, 32'd0);
      else begin
        mon_r = resp_q.pop_front();
        $display("resp %0d: cycle=%0d rdata=%08h err=%0d", nresp, cycle, bus.resp_rdata, bus.resp_err);
        check(bus.resp_rdata == mon_r.rdata, "resp_rdata", bus.resp_rdata, mon_r.rdata);
        check(bus.resp_err == mon_r.err, "resp_err", {31'd0, bus.resp_err}, {31'd0, mon_r.err});
        check(cycle == mon_r.cyc, "resp_latency", 32'(cycle), 32'(mon_r.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;

    @(negedge clk);
    check(bus.req_ready == 1'b0, "rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check(bus.resp_valid == 1'b0 && bus.resp_err == 1'b0, "rst_resp_flags", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    check(bus.resp_rdata == 32'd0, "rst_resp_rdata", bus.resp_rdata, 32'd0);
    check(DMEM_address == 32'd0 && DMEM_data_in == 32'd0, "rst_dmem_bus", DMEM_address | DMEM_data_in, 32'd0);
    check(!DMEM_mem_read && !DMEM_mem_write, "rst_dmem_strobes", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check(bus.req_ready == 1'b1, "ready_after_init", {31'd0, bus.req_ready}, 32'd1);

    // Directed cases, valid held high so every accept gap is checked.
    issue(1, SZ_WORD, 0, 32'd20, 32'h12345678, 0, 32'd0, 1);
    issue(0, SZ_WORD, 0, 32'd20, 32'd0, 1, 32'h12345678, 1);
    issue(1, SZ_WORD, 0, 32'd40, 32'h00000078, 0, 32'd0, 1);
    issue(1, SZ_BYTE, 0, 32'd41, 32'h000000AB, 0, 32'd0, 1);
    issue(0, SZ_WORD, 0, 32'd40, 32'd0, 1, 32'h0000AB78, 1);
    issue(0, SZ_BYTE, 0, 32'd41, 32'd0, 1, 32'hFFFFFFAB, 1);
    issue(0, SZ_BYTE, 1, 32'd41, 32'd0, 1, 32'h000000AB, 1);
    issue(1, SZ_WORD, 0, 32'd40, 32'h80017FFF, 0, 32'd0, 1);
    issue(0, SZ_HALF, 0, 32'd42, 32'd0, 1, 32'hFFFF8001, 1);
    issue(0, SZ_HALF, 0, 32'd40, 32'd0, 1, 32'h00007FFF, 1);
    issue(0, SZ_HALF, 1, 32'd42, 32'd0, 1, 32'h00008001, 1);
    issue(0, SZ_WORD, 0, 32'd22, 32'd0, 1, 32'd0, 1);
    issue(0, 2'b11,   0, 32'd20, 32'd0, 1, 32'd0, 1);
    issue(1, SZ_HALF, 0, 32'd41, 32'hDEAD, 1, 32'd0, 1);
    issue(1, 2'b11,   0, 32'd44, 32'h55, 1, 32'd0, 1);
    issue(1, SZ_HALF, 0, 32'd46, 32'hBEEF, 0, 32'd0, 1);
    issue(0, SZ_WORD, 0, 32'd44, 32'd0, 0, 32'd0, 1);
    idle(3);

    // Reset while the byte store sits in CAP: no write, no response.
    issue(1, SZ_BYTE, 0, 32'd41, 32'h000000CD, 0, 32'd0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check(bus.req_ready == 1'b0, "midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check(!DMEM_mem_write && !bus.resp_valid, "midrst_quiet", {30'd0, DMEM_mem_write, bus.resp_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check(bus.req_ready == 1'b1, "ready_after_release", {31'd0, bus.req_ready}, 32'd1);
    idle(4);
    issue(0, SZ_WORD, 0, 32'd40, 32'd0, 1, 32'h80017FFF, 1);

    // Randomized mix against the byte-level reference memory.
    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), 0, 32'd0, 1);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    check(resp_q.size() == 0, "resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check(wr_q.size() == 0, "write_queue_drained", 32'(wr_q.size()), 32'd0);
    check(rd_q.size() == 0, "read_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
